alu_pipe_hs: RTL and testbench

//  Parametrised, registered ALU with the 16-op opcode map of the 8-bit combinational ALU.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_div_iter.sv | 80 ++++++++
 rtl/alu_pipe_hs.sv | 187 ++++++++++++++++++
 tb/tb_alu_pipe_hs.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and flag bundle for the handshaked ALU.
// The opcode values match the original 8-bit combinational ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_ROL  = 4'h6;
    localparam logic [3:0] OP_ROR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_div_iter.sv
// Restoring shift-subtract divider: one quotient bit per cycle, MSB first.
// The quotient is built in place by shifting it into the dividend register.
module alu_div_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             last,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    assign busy     = (cnt_q != '0);
    assign last     = (cnt_q == CNT_W'(1));
    assign done     = done_q;
    assign quotient = quo_q;

    // A negative trial (top bit set) means the divisor did not fit: keep the shifted remainder.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        if (start) begin
            quo_d  = dividend;
            dvs_d  = divisor;
            rem_d  = '0;
            cnt_d  = CNT_W'(WIDTH);
            done_d = 1'b0;
        end else if (busy) begin
            if (trial[WIDTH]) begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end else begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (last) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/alu_pipe_hs.sv
// Registered 16-op ALU with valid/ready on both sides, status flags and an iterative divider.
// Handshake: a beat moves on a rising edge where valid && ready; the producer holds its beat until then.
module alu_pipe_hs
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output alu_state_e       fsm_state
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    alu_flags_t       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;

    logic             out_free;
    logic             accept;
    logic             is_div;
    logic             div_start;
    logic             div_busy;
    logic             div_last;
    logic             div_done;
    logic [WIDTH-1:0] div_quot;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   op_res;
    logic               op_c;
    logic               op_v;

    assign out_free  = !out_valid_q || out_ready;
    assign in_ready  = (state_q == ST_IDLE) && !div_busy && out_free;
    assign accept    = in_valid && in_ready;
    assign is_div    = (ALU_Sel == OP_DIV) && (B != '0);
    assign div_start = accept && is_div;

    alu_div_iter #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (A),
        .divisor  (B),
        .busy     (div_busy),
        .last     (div_last),
        .done     (div_done),
        .quotient (div_quot)
    );

    // Single-cycle datapath; the OP_DIV arm only ever reaches the output for B == 0.
    always_comb begin
        sum    = {1'b0, A} + {1'b0, B};
        diff   = {1'b0, A} - {1'b0, B};
        prod   = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        op_res = '0;
        op_c   = 1'b0;
        op_v   = 1'b0;
        case (ALU_Sel)
            OP_ADD: begin
                op_res = sum[WIDTH-1:0];
                op_c   = sum[WIDTH];
                op_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                op_res = diff[WIDTH-1:0];
                op_c   = diff[WIDTH];
                op_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_MUL: begin
                op_res = prod[WIDTH-1:0];
                op_c   = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                op_res = '1;
                op_v   = 1'b1;
            end
            OP_SHL: begin
                op_res = {A[WIDTH-2:0], 1'b0};
                op_c   = A[WIDTH-1];
            end
            OP_SHR: begin
                op_res = {1'b0, A[WIDTH-1:1]};
                op_c   = A[0];
            end
            OP_ROL: begin
                op_res = {A[WIDTH-2:0], A[WIDTH-1]};
                op_c   = A[WIDTH-1];
            end
            OP_ROR: begin
                op_res = {A[0], A[WIDTH-1:1]};
                op_c   = A[0];
            end
            OP_AND:  op_res = A & B;
            OP_OR:   op_res = A | B;
            OP_XOR:  op_res = A ^ B;
            OP_NOR:  op_res = ~(A | B);
            OP_NAND: op_res = ~(A & B);
            OP_XNOR: op_res = ~(A ^ B);
            OP_GT:   op_res = {{(WIDTH-1){1'b0}}, (A > B)};
            OP_EQ:   op_res = {{(WIDTH-1){1'b0}}, (A == B)};
            default: op_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        if (out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_div) begin
                        state_d = ST_DIV;
                    end else begin
                        result_d    = op_res;
                        flags_d.z   = (op_res == '0);
                        flags_d.n   = op_res[WIDTH-1];
                        flags_d.c   = op_c;
                        flags_d.v   = op_v;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_DIV: begin
                if (div_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Stall here until the output register can take the quotient.
                if (div_done && out_free) begin
                    result_d    = div_quot;
                    flags_d.z   = (div_quot == '0);
                    flags_d.n   = div_quot[WIDTH-1];
                    flags_d.c   = 1'b0;
                    flags_d.v   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign ALU_Result = result_q;
    assign flag_z     = flags_q.z;
    assign flag_n     = flags_q.n;
    assign flag_c     = flags_q.c;
    assign flag_v     = flags_q.v;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_alu_pipe_hs.sv
// Bench for alu_pipe_hs (WIDTH=8): directed vector table, handshake/divide/reset sequences,
// then random traffic with backpressure scored against an arithmetic reference model.
module tb_alu_pipe_hs;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   ALU_Sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALU_Result;
  logic         flag_z;
  logic         flag_n;
  logic         flag_c;
  logic         flag_v;
  alu_state_e   fsm_state;

  int n_cmp;
  int n_bad;
  logic [W+3:0] exp_q[$];

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   f;
    int           lat;
  } vec_t;

  vec_t tv[$];

  alu_pipe_hs #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .ALU_Sel    (ALU_Sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALU_Result (ALU_Result),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .flag_c     (flag_c),
    .flag_v     (flag_v),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] cur_flags();
    return {flag_z, flag_n, flag_c, flag_v};
  endfunction

  // Reference model from plain arithmetic: returns {result, z, n, c, v}.
  function automatic logic [W+3:0] ref_alu(input int op, input int a, input int b);
    int r;
    int sa;
    int sb;
    int sr;
    logic c;
    logic v;
    logic [W-1:0] la;
    logic [W-1:0] lb;
    logic [W-1:0] lr;
    c  = 1'b0;
    v  = 1'b0;
    r  = 0;
    la = a[W-1:0];
    lb = b[W-1:0];
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (op)
      0: begin r = a + b; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
      1: begin r = a - b; c = (a < b);   sr = sa - sb; v = (sr > 127) || (sr < -128); end
      2: begin r = a * b; c = (r > 255); end
      3: begin
        if (b == 0) begin r = 255; v = 1'b1; end
        else r = a / b;
      end
      4: begin r = a * 2;                 c = (a >= 128); end
      5: begin r = a / 2;                 c = (a % 2 == 1); end
      6: begin r = a * 2 + a / 128;       c = (a >= 128); end
      7: begin r = a / 2 + (a % 2) * 128; c = (a % 2 == 1); end
      8:  r = int'(la & lb);
      9:  r = int'(la | lb);
      10: r = int'(la ^ lb);
      11: r = int'(~(la | lb));
      12: r = int'(~(la & lb));
      13: r = int'(~(la ^ lb));
      14: r = (a > b) ? 1 : 0;
      default: r = (a == b) ? 1 : 0;
    endcase
    lr = r[W-1:0];
    return {lr, (lr == 0), lr[W-1], c, v};
  endfunction

  // driver tasks
  task automatic add_vec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic [3:0] f, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.f = f; v.lat = lat;
    tv.push_back(v);
  endtask

  // Enters and leaves at posedge+1 with out_ready high.
  task automatic run_vec(input vec_t v, input int idx);
    int wait_n;
    int lat;
    ALU_Sel   = v.op;
    A         = v.a;
    B         = v.b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    wait_n    = 0;
    while (!in_ready && wait_n < 20) begin
      @(posedge clk); #1;
      wait_n++;
    end
    chk($sformatf("vec%0d_accept", idx), in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("vec%0d_latency", idx), lat, v.lat);
    chk($sformatf("vec%0d_result", idx), ALU_Result, v.res);
    chk($sformatf("vec%0d_flags_zncv", idx), cur_flags(), v.f);
    @(posedge clk); #1;
  endtask

  task automatic sb_pop();
    if (exp_q.size() == 0) chk("sb_unexpected_output", 1, 0);
    else chk("sb_result_flags", {ALU_Result, cur_flags()}, exp_q.pop_front());
  endtask

  initial begin
    logic         held_v;
    logic [W+3:0] held;
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    ALU_Sel   = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", ALU_Result, 0);
    chk("rst_flags", cur_flags(), 0);
    chk("rst_fsm", fsm_state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);

    // vector table: op, A, B, result, {z,n,c,v}, cycles after accept edge
    add_vec(4'h0, 8'h0A, 8'h03, 8'h0D, 4'b0000, 0);
    add_vec(4'h0, 8'h7F, 8'h01, 8'h80, 4'b0101, 0);
    add_vec(4'h0, 8'hFF, 8'h01, 8'h00, 4'b1010, 0);
    add_vec(4'h1, 8'h0A, 8'h03, 8'h07, 4'b0000, 0);
    add_vec(4'h1, 8'h03, 8'h0A, 8'hF9, 4'b0110, 0);
    add_vec(4'h1, 8'h80, 8'h01, 8'h7F, 4'b0001, 0);
    add_vec(4'h2, 8'h0F, 8'h03, 8'h2D, 4'b0000, 0);
    add_vec(4'h2, 8'h10, 8'h10, 8'h00, 4'b1010, 0);
    add_vec(4'h3, 8'h0A, 8'h03, 8'h03, 4'b0000, 9);
    add_vec(4'h3, 8'hFF, 8'h10, 8'h0F, 4'b0000, 9);
    add_vec(4'h3, 8'h0A, 8'h00, 8'hFF, 4'b0101, 0);
    add_vec(4'h4, 8'h81, 8'h00, 8'h02, 4'b0010, 0);
    add_vec(4'h5, 8'h81, 8'h00, 8'h40, 4'b0010, 0);
    add_vec(4'h6, 8'h81, 8'h00, 8'h03, 4'b0010, 0);
    add_vec(4'h7, 8'h81, 8'h00, 8'hC0, 4'b0110, 0);
    add_vec(4'h8, 8'h0A, 8'h03, 8'h02, 4'b0000, 0);
    add_vec(4'h9, 8'h0A, 8'h03, 8'h0B, 4'b0000, 0);
    add_vec(4'hA, 8'h0A, 8'h03, 8'h09, 4'b0000, 0);
    add_vec(4'hB, 8'h0A, 8'h03, 8'hF4, 4'b0100, 0);
    add_vec(4'hC, 8'h0A, 8'h03, 8'hFD, 4'b0100, 0);
    add_vec(4'hD, 8'h0A, 8'h03, 8'hF6, 4'b0100, 0);
    add_vec(4'hE, 8'h0A, 8'h03, 8'h01, 4'b0000, 0);
    add_vec(4'hE, 8'h03, 8'h0A, 8'h00, 4'b1000, 0);
    add_vec(4'hF, 8'h55, 8'h55, 8'h01, 4'b0000, 0);
    add_vec(4'hF, 8'h55, 8'h54, 8'h00, 4'b1000, 0);
    for (int i = 0; i < tv.size(); i++) run_vec(tv[i], i);

    // divide: in_ready low and FSM busy for the 9 cycles after accept
    ALU_Sel = 4'h3; A = 8'h0A; B = 8'h03; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int j = 0; j < 9; j++) begin
      chk($sformatf("div_in_ready_c%0d", j), in_ready, 0);
      chk($sformatf("div_out_valid_c%0d", j), out_valid, 0);
      chk($sformatf("div_fsm_c%0d", j), fsm_state, (j == 8) ? ST_DONE : ST_IDLE + 2'd1);
      @(posedge clk); #1;
    end
    chk("div_out_valid", out_valid, 1);
    chk("div_result", ALU_Result, 8'h03);
    chk("div_in_ready_after", in_ready, 1);
    @(posedge clk); #1;

    // divide by zero never leaves IDLE
    ALU_Sel = 4'h3; A = 8'h0A; B = 8'h00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("dz_fsm", fsm_state, ST_IDLE);
    chk("dz_out_valid", out_valid, 1);
    chk("dz_result", ALU_Result, 8'hFF);
    chk("dz_flags", cur_flags(), 4'b0101);
    @(posedge clk); #1;

    // back-to-back 0,1,8 then 3 cycles of backpressure
    A = 8'h0A; B = 8'h03; in_valid = 1'b1; ALU_Sel = 4'h0;
    @(posedge clk); #1;
    chk("b2b_add", {out_valid, ALU_Result}, {1'b1, 8'h0D});
    chk("b2b_in_ready0", in_ready, 1);
    ALU_Sel = 4'h1;
    @(posedge clk); #1;
    chk("b2b_sub", {out_valid, ALU_Result}, {1'b1, 8'h07});
    chk("b2b_in_ready1", in_ready, 1);
    ALU_Sel = 4'h8;
    @(posedge clk); #1;
    chk("b2b_and", {out_valid, ALU_Result}, {1'b1, 8'h02});
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready_now", in_ready, 0);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_c%0d", j), {out_valid, ALU_Result}, {1'b1, 8'h02});
      chk($sformatf("bp_in_ready_c%0d", j), in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released", out_valid, 0);

    // reset 4 cycles into a divide
    ALU_Sel = 4'h3; A = 8'h0A; B = 8'h03; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_result", ALU_Result, 0);
    chk("mid_rst_fsm", fsm_state, ST_IDLE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_no_result", out_valid, 0);
    begin
      vec_t v;
      v.op = 4'h2; v.a = 8'h20; v.b = 8'h10; v.res = 8'h00; v.f = 4'b1010; v.lat = 0;
      run_vec(v, 99);
    end

    // random traffic with backpressure against the reference model
    held_v = 1'b0;
    held   = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      ALU_Sel   = ($urandom_range(0, 3) == 0) ? 4'h3 : 4'($urandom_range(0, 15));
      A         = W'($urandom);
      B         = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (held_v) chk("rand_hold_stable", {out_valid, ALU_Result, cur_flags()}, {1'b1, held});
      held_v = out_valid && !out_ready;
      held   = {ALU_Result, cur_flags()};
      if (out_valid && out_ready) sb_pop();
      if (in_valid && in_ready) exp_q.push_back(ref_alu(int'(ALU_Sel), int'(A), int'(B)));
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      if (out_valid) sb_pop();
      @(posedge clk); #1;
    end
    chk("drain_queue_empty", exp_q.size(), 0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
